// File: rtl/recolector_pkg.sv
// Shared debug package: dump-size defaults and collector FSM encodings.
package recolector_pkg;

    localparam int LEN_DEF       = 32;
    localparam int CANT_REGS_DEF = 32;
    localparam int CANT_MEM_DEF  = 16;

    typedef enum logic [1:0] {
        S_REGS = 2'd0,
        S_MEM  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/recolector.sv
// Debug word collector: walks the register file, then the data memory,
// presenting one registered word per enable_next pulse.
module recolector
    import recolector_pkg::*;
#(
    parameter int len            = LEN_DEF,
    parameter int cant_regs      = CANT_REGS_DEF,
    parameter int cant_mem_datos = CANT_MEM_DEF,
    localparam int NB_reg = $clog2(cant_regs),
    localparam int NB_mem = $clog2(cant_mem_datos)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              send_regs,
    input  logic              enable_next,
    input  logic [len-1:0]    reg_data,
    output logic [NB_reg-1:0] reg_addr,
    input  logic [len-1:0]    mem_data,
    output logic [NB_mem-1:0] mem_addr,
    output logic [len-1:0]    data_out,
    output logic              ready,
    output logic              done,
    output logic              overrun,
    output logic [7:0]        word_count
);

    localparam logic [NB_reg:0] REG_END = cant_regs[NB_reg:0];
    localparam logic [NB_reg:0] REG_ONE = 1;
    localparam logic [NB_mem:0] MEM_END = cant_mem_datos[NB_mem:0];
    localparam logic [NB_mem:0] MEM_ONE = 1;

    state_t            state_q, state_d;
    logic [NB_reg:0]   reg_ptr_q, reg_ptr_d;
    logic [NB_mem:0]   mem_ptr_q, mem_ptr_d;
    logic [NB_mem:0]   mem_ptr_inc;
    logic [len-1:0]    data_q, data_d;
    logic [7:0]        wc_q, wc_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              take_reg, take_mem, drop;

    always_comb begin
        state_d     = state_q;
        reg_ptr_d   = reg_ptr_q;
        mem_ptr_d   = mem_ptr_q;
        data_d      = data_q;
        wc_d        = wc_q;
        ovr_d       = ovr_q;
        take_reg    = 1'b0;
        take_mem    = 1'b0;
        drop        = 1'b0;
        mem_ptr_inc = mem_ptr_q + MEM_ONE;

        if (enable_next && state_q != S_DONE) begin
            if (send_regs) begin
                if (state_q == S_REGS && reg_ptr_q < REG_END) take_reg = 1'b1;
                else drop = 1'b1;
            end else if (ready_q) begin
                take_mem = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        if (take_reg) begin
            data_d    = reg_data;
            reg_ptr_d = reg_ptr_q + REG_ONE;
        end
        if (take_mem) begin
            data_d    = mem_data;
            mem_ptr_d = mem_ptr_inc;
            state_d   = (mem_ptr_inc == MEM_END) ? S_DONE : S_MEM;
        end
        if ((take_reg || take_mem) && wc_q != 8'hFF) wc_d = wc_q + 8'd1;
        if (drop) ovr_d = 1'b1;

        // the synchronous memory needs one edge to follow a new address
        ready_d = !take_mem;

        if (restart) begin
            state_d   = S_REGS;
            reg_ptr_d = '0;
            mem_ptr_d = '0;
            data_d    = '0;
            wc_d      = '0;
            ovr_d     = 1'b0;
            ready_d   = 1'b0;
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_REGS;
            reg_ptr_q <= '0;
            mem_ptr_q <= '0;
            data_q    <= '0;
            wc_q      <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_ptr_q <= reg_ptr_d;
            mem_ptr_q <= mem_ptr_d;
            data_q    <= data_d;
            wc_q      <= wc_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    assign reg_addr   = reg_ptr_q[NB_reg-1:0];
    assign mem_addr   = mem_ptr_q[NB_mem-1:0];
    assign data_out   = data_q;
    assign ready      = ready_q;
    assign done       = done_q;
    assign overrun    = ovr_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_recolector.sv
// Directed dump scenarios plus random pulses, checked against a
// word-counting reference of the collector's delivery rules.
module tb_recolector;

    localparam int LEN = 32;
    localparam int CR  = 32;
    localparam int CM  = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            restart = 1'b0;
    logic            send_regs = 1'b0;
    logic            enable_next = 1'b0;
    logic [LEN-1:0]  reg_data;
    logic [4:0]      reg_addr;
    logic [LEN-1:0]  mem_data = '0;
    logic [3:0]      mem_addr;
    logic [LEN-1:0]  data_out;
    logic            ready, done, overrun;
    logic [7:0]      word_count;

    logic [LEN-1:0]  regfile [CR];
    logic [LEN-1:0]  mem_img [CM];

    int vectors = 0;
    int miscompares = 0;

    // reference: words taken from each source, last word, flags
    int             m_r, m_m, m_wc;
    logic [LEN-1:0] m_data;
    bit             m_ready, m_done, m_ovr;

    recolector dut (
        .clk(clk), .reset(reset), .restart(restart),
        .send_regs(send_regs), .enable_next(enable_next),
        .reg_data(reg_data), .reg_addr(reg_addr),
        .mem_data(mem_data), .mem_addr(mem_addr),
        .data_out(data_out), .ready(ready), .done(done),
        .overrun(overrun), .word_count(word_count)
    );

    always #5 clk = ~clk;

    assign reg_data = regfile[reg_addr];
    always @(posedge clk) mem_data <= mem_img[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_r = 0; m_m = 0; m_wc = 0; m_data = '0;
        m_ready = 0; m_done = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit en, input bit sr, input bit rs);
        bit acc_r, acc_m, bad;
        if (rs) begin
            model_reset();
            return;
        end
        acc_r = 0; acc_m = 0; bad = 0;
        if (en && !m_done) begin
            if (sr) begin
                if (m_m == 0 && m_r < CR) acc_r = 1;
                else bad = 1;
            end else begin
                if (m_ready) acc_m = 1;
                else bad = 1;
            end
        end
        m_ready = !acc_m;
        if (acc_r) begin
            m_data = regfile[m_r];
            m_r++;
        end
        if (acc_m) begin
            m_data = mem_img[m_m];
            m_m++;
            if (m_m == CM) m_done = 1;
        end
        if ((acc_r || acc_m) && m_wc < 255) m_wc++;
        if (bad) m_ovr = 1;
    endtask

    task automatic check_all();
        chk("data_out", data_out, m_data);
        chk("word_count", {24'd0, word_count}, m_wc);
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("reg_addr", {27'd0, reg_addr}, m_r % CR);
        chk("mem_addr", {28'd0, mem_addr}, m_m % CM);
    endtask

    task automatic step(input bit en, input bit sr, input bit rs);
        @(negedge clk);
        enable_next = en;
        send_regs   = sr;
        restart     = rs;
        @(posedge clk);
        model_edge(en, sr, rs);
        #1;
        enable_next = 1'b0;
        restart     = 1'b0;
        check_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_data_zero", data_out, 32'h0);
        chk("rst_flags_zero", {ready, done, overrun}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < CR; i++) regfile[i] = 32'hA000_0000 + i;
        for (int j = 0; j < CM; j++) mem_img[j] = 32'h0000_B000 + j;

        // full dump: registers then spaced memory reads
        async_reset();
        step(0, 0, 0);
        chk("ready_after_release", {31'd0, ready}, 32'd1);
        for (int i = 0; i < CR; i++) step(1, 1, 0);
        chk("regs_last", data_out, 32'hA000_001F);
        chk("regs_count", {24'd0, word_count}, 32'd32);
        for (int j = 0; j < CM; j++) begin
            step(1, 0, 0);
            chk("mem_word", data_out, 32'h0000_B000 + j);
            for (int k = 0; k < 4; k++) step(0, 0, 0);
        end
        chk("dump_done", {31'd0, done}, 32'd1);
        chk("dump_count", {24'd0, word_count}, 32'd48);
        chk("dump_ovr", {31'd0, overrun}, 32'd0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("done_hold", data_out, 32'h0000_B00F);

        // 33rd register pulse is refused
        step(0, 0, 1);
        for (int i = 0; i < CR; i++) step(1, 1, 0);
        step(1, 1, 0);
        chk("reg33_hold", data_out, 32'hA000_001F);
        chk("reg33_ovr", {31'd0, overrun}, 32'd1);

        // back-to-back memory pulses, then restart at word 40
        step(0, 0, 1);
        for (int i = 0; i < CR; i++) step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("b2b_ovr", {31'd0, overrun}, 32'd1);
        chk("b2b_addr", {28'd0, mem_addr}, 32'd2);
        chk("b2b_data", data_out, 32'h0000_B001);
        for (int j = 2; j < 8; j++) begin
            step(0, 0, 0);
            step(1, 0, 0);
        end
        chk("word40", {24'd0, word_count}, 32'd40);
        step(1, 1, 1);
        chk("rs_count", {24'd0, word_count}, 32'd0);
        chk("rs_data", data_out, 32'h0);
        chk("rs_flags", {ready, done, overrun}, 32'h0);
        step(1, 1, 0);
        chk("rs_reg0", data_out, 32'hA000_0000);

        // reset in the middle of a dump
        for (int i = 0; i < 5; i++) step(1, 1, 0);
        async_reset();

        // random pulses with fresh contents
        for (int i = 0; i < CR; i++) regfile[i] = $urandom;
        for (int j = 0; j < CM; j++) mem_img[j] = $urandom;
        step(0, 0, 1);
        for (int n = 0; n < 1500; n++) begin
            bit en, sr, rs;
            en = ($urandom_range(0, 99) < 60);
            sr = (m_r < CR && m_m == 0) ? ($urandom_range(0, 99) < 85)
                                       : ($urandom_range(0, 99) < 10);
            rs = ($urandom_range(0, 199) == 0);
            step(en, sr, rs);
            if (n == 700) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/recolector.md
RECOLECTOR -- requirements
Module: recolector

Interface
REQ-001 SHALL have parameter len, default 32: width of every data word.
REQ-002 SHALL have parameter cant_regs, default 32: register-file words per dump.
REQ-003 SHALL have parameter cant_mem_datos, default 16: data-memory words per dump.
REQ-004 SHALL derive NB_reg = $clog2(cant_regs) and NB_mem = $clog2(cant_mem_datos).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 restart  input  1  synchronous restart, driven by restart_recolector.
REQ-008 send_regs  input  1  source select, driven by send_regs_recolector: 1 selects register file, 0 selects data memory.
REQ-009 enable_next  input  1  one-cycle advance pulse, driven by enable_next_recolector.
REQ-010 reg_data  input  len  register-file debug read port; combinational read of reg_addr.
REQ-011 reg_addr  output  NB_reg  register-file debug read address.
REQ-012 mem_data  input  len  data-memory debug read port; synchronous read, one-cycle latency from mem_addr.
REQ-013 mem_addr  output  NB_mem  data-memory debug read address.
REQ-014 data_out  output  len  registered word; feeds the recolector input of the debug state machine.
REQ-015 ready  output  1  mem_data is valid for the current mem_addr.
REQ-016 done  output  1  all cant_regs+cant_mem_datos words delivered.
REQ-017 overrun  output  1  sticky; set when a pulse is dropped illegally.
REQ-018 word_count  output  8  number of words latched since restart; saturates at 255.

Function
REQ-019 SHALL implement FSM states S_REGS, S_MEM and S_DONE.
REQ-020 SHALL drive reg_addr from reg_ptr[NB_reg-1:0] and mem_addr from mem_ptr, both continuously.
- reg_ptr is NB_reg+1 bits wide; mem_ptr is NB_mem+1 bits wide.
REQ-021 In S_REGS, enable_next=1 with send_regs=1 and reg_ptr<cant_regs SHALL latch reg_data into data_out and increment reg_ptr, with no latency beyond the edge.
REQ-022 In S_REGS, enable_next=1 with send_regs=0 and ready=1 SHALL latch mem_data (word 0) into data_out, increment mem_ptr and go to S_MEM.
REQ-023 In S_MEM, enable_next=1 with send_regs=0 and ready=1 SHALL latch mem_data and increment mem_ptr.
- When the incremented mem_ptr equals cant_mem_datos, the FSM SHALL go to S_DONE.
REQ-024 ready SHALL be 0 for exactly the one cycle after any mem_ptr change (increment, restart or reset release), and 1 otherwise.
REQ-025 In S_REGS or S_MEM, the following pulses SHALL be ignored and SHALL set overrun:
- any pulse while ready=0 that would take a memory word;
- send_regs=1 when reg_ptr=cant_regs;
- send_regs=1 in S_MEM.
REQ-026 In S_DONE, done=1 and every pulse SHALL be ignored, with data_out held and overrun unchanged.
REQ-027 word_count SHALL increment on every accepted latch and saturate at 255.
REQ-028 A restart SHALL take one cycle and:
- set state to S_REGS;
- set reg_ptr, mem_ptr, data_out, word_count, done and overrun to 0, and ready to 0.
REQ-029 If restart and enable_next are both high in the same cycle, restart SHALL win and the pulse SHALL be dropped without setting overrun.
REQ-030 SHALL have no combinational path from any input to data_out, done, overrun or word_count.

Reset
REQ-031 Asynchronous assertion of reset SHALL immediately set:
- state to S_REGS;
- reg_ptr, mem_ptr, data_out, word_count, ready, done and overrun to 0.
REQ-032 After reset release, ready SHALL rise on the first clk edge.
REQ-033 Reset asserted mid-dump SHALL abandon the dump; no partial state is retained.

Structure
REQ-034 A shared debug package SHALL hold:
- the FSM state encodings;
- the defaults for len, cant_regs and cant_mem_datos, shared with the debug state machine.
REQ-035 The block SHALL be a single module with no sub-modules.
- The pointer/ready logic is small enough that splitting it adds nothing.

Verification
REQ-036 Reset, then 32 pulses with send_regs=1 and regfile[i]=0xA0000000+i -> data_out steps through 0xA0000000..0xA000001F; word_count=32.
REQ-037 Continue with 16 pulses with send_regs=0, spaced 5 cycles apart, and mem[j]=0xB000+j -> data_out steps through 0xB000..0xB00F; done=1; word_count=48; overrun=0.
REQ-038 In S_MEM, give two pulses on consecutive cycles -> the second is dropped; overrun=1; mem_ptr advanced by only one.
REQ-039 Give a 33rd pulse with send_regs=1 -> data_out holds 0xA000001F; overrun=1.
REQ-040 At word 40, give restart together with enable_next -> next cycle state=S_REGS, word_count=0, data_out=0, overrun=0, ready=0; a later pulse latches regfile[0].
REQ-041 Assert reset asynchronously mid-dump, between clock edges -> all outputs read 0 before the next edge.
